// File: rtl/or_truth_table_sequencer_if.sv
// Bus between the OR truth-table sequencer and the environment around it:
// run control, gate stimulus/response and the result registers.
interface or_truth_table_sequencer_if #(
    parameter int N_INPUTS = 2
);
    logic                start;
    logic [N_INPUTS-1:0] vec;
    logic                dut_result;
    logic                busy;
    logic                done;
    logic [N_INPUTS:0]   err_count;
    logic [N_INPUTS-1:0] first_err_vec;
    logic                first_err_valid;
    logic                pass;

    // master = the sequencer, slave = the host/gate side
    modport master (
        input  start, dut_result,
        output vec, busy, done, err_count, first_err_vec, first_err_valid, pass
    );
    modport slave (
        output start, dut_result,
        input  vec, busy, done, err_count, first_err_vec, first_err_valid, pass
    );
endinterface

// File: rtl/or_truth_table_sequencer.sv
// Walks every input vector of an OR gate from all-ones down to zero, holds each
// for SETTLE_CYCLES, samples the gate and tallies mismatches against |vec.
module or_truth_table_sequencer #(
    parameter int N_INPUTS      = 2,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                              clk,
    input  logic                              reset,
    or_truth_table_sequencer_if.master        bus
);
    localparam int CW = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SAMPLE, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [N_INPUTS-1:0] vec_q, vec_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [N_INPUTS:0]   err_q, err_d;
    logic [N_INPUTS-1:0] fvec_q, fvec_d;
    logic                fval_q, fval_d;
    logic                pass_q, pass_d;
    logic                mismatch;

    assign mismatch = (bus.dut_result != (|vec_q));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        vec_d   = vec_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;
        fvec_d  = fvec_q;
        fval_d  = fval_q;
        pass_d  = pass_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_WAIT;
                    vec_d   = '1;
                    cnt_d   = CW'(SETTLE_CYCLES);
                    err_d   = '0;
                    fval_d  = 1'b0;
                    fvec_d  = '0;
                    busy_d  = 1'b1;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = S_SAMPLE;
            end
            S_SAMPLE: begin
                if (mismatch) begin
                    err_d = err_q + (N_INPUTS+1)'(1);
                    if (!fval_q) begin
                        fvec_d = vec_q;
                        fval_d = 1'b1;
                    end
                end
                // pass must see an error found on this final vector, so use err_d
                if (vec_q == '0) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    pass_d  = (err_d == '0);
                    vec_d   = '0;
                end else begin
                    vec_d   = vec_q - N_INPUTS'(1);
                    cnt_d   = CW'(SETTLE_CYCLES);
                    state_d = S_WAIT;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            vec_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= '0;
            fvec_q  <= '0;
            fval_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vec_q   <= vec_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            fvec_q  <= fvec_d;
            fval_q  <= fval_d;
            pass_q  <= pass_d;
        end
    end

    assign bus.vec             = vec_q;
    assign bus.busy            = busy_q;
    assign bus.done            = done_q;
    assign bus.err_count       = err_q;
    assign bus.first_err_vec   = fvec_q;
    assign bus.first_err_valid = fval_q;
    assign bus.pass            = pass_q;
endmodule

// File: tb/tb_or_truth_table_sequencer.sv
// Randomized scoreboard bench: two sequencers (settle 1 and settle 3) driving
// modelled gates whose truth tables are correct, stuck or random.
module tb_or_truth_table_sequencer;
    localparam int NA = 2, SA = 1, NB = 2, SB = 3;
    localparam logic [15:0] CORRECT = 16'hFFFE;

    typedef struct {
        int t_start;
        int err;
        int fvec;
        bit fval;
        bit pass;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b;
    logic [15:0] tab_a, tab_b;
    int cyc = 0;
    int nvec = 0, nerr = 0;
    exp_t q_a[$], q_b[$];
    bit   mon_en[2];
    bit   running[2];
    int   t0[2];
    exp_t cur[2];

    or_truth_table_sequencer_if #(.N_INPUTS(NA)) if_a();
    or_truth_table_sequencer_if #(.N_INPUTS(NB)) if_b();

    or_truth_table_sequencer #(.N_INPUTS(NA), .SETTLE_CYCLES(SA)) dut_a (
        .clk(clk), .reset(rst_a), .bus(if_a));
    or_truth_table_sequencer #(.N_INPUTS(NB), .SETTLE_CYCLES(SB)) dut_b (
        .clk(clk), .reset(rst_b), .bus(if_b));

    assign if_a.dut_result = tab_a[if_a.vec];
    assign if_b.dut_result = tab_b[if_b.vec];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] want);
        nvec++;
        if (act !== want) begin
            nerr++;
            $display("FAIL %s dut%0d cyc=%0d got=%0d want=%0d", name, id, cyc, act, want);
        end
    endtask

    // Reference: walk vectors top-down, compare table entry with "any bit set".
    function automatic exp_t model(input int n, input logic [15:0] tab, input int t_start);
        exp_t e = '{default:0};
        e.t_start = t_start;
        for (int v = (1 << n) - 1; v >= 0; v--) begin
            if (tab[v] != (v != 0)) begin
                e.err++;
                if (!e.fval) begin
                    e.fval = 1'b1;
                    e.fvec = v;
                end
            end
        end
        e.pass = (e.err == 0);
        return e;
    endfunction

    task automatic mon_step(input int id, input int s, input int n, input logic b, input logic d,
                            input logic [31:0] v, input logic [31:0] er, input logic [31:0] fv,
                            input logic fvl, input logic ps);
        int per, len, m;
        per = s + 1;
        len = (1 << n) * per;
        if (!mon_en[id]) begin
            running[id] = 1'b0;
            return;
        end
        if (!running[id]) begin
            if (b !== 1'b1) begin
                chk("idle_done", id, d, 0);
                return;
            end
            if ((id == 0 ? q_a.size() : q_b.size()) == 0) begin
                chk("unexpected_run", id, 1, 0);
                cur[id] = '{default:0};
                cur[id].t_start = cyc;
            end else if (id == 0) cur[id] = q_a.pop_front();
            else cur[id] = q_b.pop_front();
            running[id] = 1'b1;
            t0[id] = cyc;
            chk("busy_latency", id, cyc, cur[id].t_start);
            chk("start_err_clear", id, er, 0);
            chk("start_fval_clear", id, fvl, 0);
        end
        m = cyc - t0[id];
        if (m < len) begin
            chk("vec", id, v, ((1 << n) - 1) - m / per);
            chk("busy", id, b, 1);
            chk("done_early", id, d, 0);
        end else if (m == len) begin
            chk("done", id, d, 1);
            chk("busy_at_done", id, b, 0);
            chk("vec_at_done", id, v, 0);
            chk("err_count", id, er, cur[id].err);
            chk("first_err_vec", id, fv, cur[id].fvec);
            chk("first_err_valid", id, fvl, cur[id].fval);
            chk("pass", id, ps, cur[id].pass);
        end else begin
            chk("hold_err_count", id, er, cur[id].err);
            chk("hold_first_err_vec", id, fv, cur[id].fvec);
            chk("hold_first_err_valid", id, fvl, cur[id].fval);
            chk("hold_pass", id, ps, cur[id].pass);
            chk("done_one_cycle", id, d, 0);
            chk("busy_after_done", id, b, 0);
            running[id] = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        mon_step(0, SA, NA, if_a.busy, if_a.done, if_a.vec, if_a.err_count, if_a.first_err_vec,
                 if_a.first_err_valid, if_a.pass);
        mon_step(1, SB, NB, if_b.busy, if_b.done, if_b.vec, if_b.err_count, if_b.first_err_vec,
                 if_b.first_err_valid, if_b.pass);
    end

    task automatic set_start(input int id, input logic val);
        if (id == 0) if_a.start = val;
        else if_b.start = val;
    endtask

    function automatic logic get_done(input int id);
        return (id == 0) ? if_a.done : if_b.done;
    endfunction

    // mode 0: start low, 1: random start pulses (ignored while busy/DONE), 2: start left as is
    task automatic wait_done(input int id, input int mode);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (mode == 1) set_start(id, 1'($urandom_range(1)));
            else if (mode == 0) set_start(id, 1'b0);
            if (get_done(id) === 1'b1) return;
        end
        chk("timeout", id, 0, 1);
    endtask

    task automatic run(input int id, input logic [15:0] tab, input int mode);
        @(negedge clk);
        if (id == 0) begin
            tab_a = tab;
            q_a.push_back(model(NA, tab, cyc + 1));
        end else begin
            tab_b = tab;
            q_b.push_back(model(NB, tab, cyc + 1));
        end
        set_start(id, 1'b1);
        wait_done(id, mode);
    endtask

    task automatic chk_zero(input string tag, input int id);
        if (id == 0) begin
            chk({tag, "_vec"}, 0, if_a.vec, 0);
            chk({tag, "_busy"}, 0, if_a.busy, 0);
            chk({tag, "_done"}, 0, if_a.done, 0);
            chk({tag, "_err"}, 0, if_a.err_count, 0);
            chk({tag, "_fvec"}, 0, if_a.first_err_vec, 0);
            chk({tag, "_fval"}, 0, if_a.first_err_valid, 0);
            chk({tag, "_pass"}, 0, if_a.pass, 0);
        end else begin
            chk({tag, "_vec"}, 1, if_b.vec, 0);
            chk({tag, "_busy"}, 1, if_b.busy, 0);
            chk({tag, "_done"}, 1, if_b.done, 0);
            chk({tag, "_err"}, 1, if_b.err_count, 0);
            chk({tag, "_fvec"}, 1, if_b.first_err_vec, 0);
            chk({tag, "_fval"}, 1, if_b.first_err_valid, 0);
            chk({tag, "_pass"}, 1, if_b.pass, 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        if_a.start = 1'b0; if_b.start = 1'b0;
        tab_a = CORRECT; tab_b = CORRECT;
        mon_en[0] = 1'b0; mon_en[1] = 1'b0;
        repeat (2) @(negedge clk);
        chk_zero("reset", 0);
        chk_zero("reset", 1);
        rst_a = 1'b0; rst_b = 1'b0;
        @(negedge clk);
        mon_en[0] = 1'b1; mon_en[1] = 1'b1;
        fork
            begin
                run(0, CORRECT, 0);        // correct gate
                run(0, 16'h0000, 0);       // stuck-at-0
                run(0, 16'hFFFF, 0);       // stuck-at-1: error only on final vector
                run(0, CORRECT, 1);        // stray start pulses, incl. during DONE
                // reset mid-run, with errors already counted
                @(negedge clk);
                tab_a = 16'h0000;
                q_a.push_back(model(NA, 16'h0000, cyc + 1));
                if_a.start = 1'b1;
                @(negedge clk);
                if_a.start = 1'b0;
                repeat (4) @(negedge clk);
                mon_en[0] = 1'b0;
                rst_a = 1'b1;
                q_a.delete();
                @(negedge clk);
                chk_zero("midrun_reset", 0);
                rst_a = 1'b0;
                @(negedge clk);
                mon_en[0] = 1'b1;
                run(0, CORRECT, 0);
                // start held high: second run accepted in the IDLE cycle after DONE
                @(negedge clk);
                tab_a = 16'h0005;
                q_a.push_back(model(NA, 16'h0005, cyc + 1));
                q_a.push_back(model(NA, 16'h0005, cyc + 1 + (1 << NA) * (SA + 1) + 2));
                if_a.start = 1'b1;
                wait_done(0, 2);
                wait_done(0, 2);
                @(negedge clk);
                if_a.start = 1'b0;
                repeat (20) run(0, 16'($urandom), int'($urandom_range(1)));
                @(negedge clk);
                if_a.start = 1'b0;
            end
            begin
                run(1, CORRECT, 0);        // settle 3
                run(1, 16'h0000, 0);
                repeat (10) run(1, 16'($urandom), int'($urandom_range(1)));
                @(negedge clk);
                if_b.start = 1'b0;
            end
        join
        repeat (4) @(negedge clk);
        chk("queue_drained", 0, q_a.size(), 0);
        chk("queue_drained", 1, q_b.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
